// File: rtl/hist_pkg.sv
// hist_pkg: shared constants and state encoding for the histogram readout controller
package hist_pkg;

    localparam int HIST_READ_LATENCY = 3;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} readout_state_t;

endpackage

// File: rtl/hist_readout_ctrl_if.sv
// hist_readout_ctrl_if: AXI-Stream bundle carrying swept bin counts out of the controller
interface hist_readout_ctrl_if #(
    parameter int WS = 32
);

    logic [WS-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);

endinterface

// File: rtl/hist_readout_fifo.sv
// hist_readout_fifo: first-word-fall-through buffer between histogram returns and the output stream
module hist_readout_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0] count_q, count_d;

    // pointer and occupancy updates; the depth is a power of two so pointers wrap on their own
    always_comb begin
        wr_d    = wr_q + PW'(push);
        rd_d    = rd_q + PW'(pop);
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // storage needs no reset: nothing is read until it has been written
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/hist_readout_ctrl.sv
// hist_readout_ctrl: owns the histogram address port, passing bins through or sweeping read-and-clear to AXIS
module hist_readout_ctrl
    import hist_pkg::*;
#(
    parameter int HIST_MEM_DEPTH      = 4096,
    parameter int HIST_WORD_SIZE      = 32,
    parameter int HIST_MEM_ADDR_WIDTH = $clog2(HIST_MEM_DEPTH),
    parameter int FIFO_DEPTH          = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           readout_start,
    output logic                           busy,
    output logic                           done,
    input  logic [HIST_MEM_ADDR_WIDTH-1:0] bin_addr_in,
    input  logic                           bin_valid_in,
    output logic [31:0]                    dropped_count,
    output logic [HIST_MEM_ADDR_WIDTH-1:0] hist_address,
    output logic                           hist_valid,
    output logic                           hist_read,
    output logic                           hist_rst,
    input  logic [HIST_WORD_SIZE-1:0]      hist_data,
    input  logic                           hist_data_valid,
    input  logic                           hist_last,
    hist_readout_ctrl_if.master            m_axis
);

    localparam int AW = HIST_MEM_ADDR_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AW-1:0] LAST_BIN = AW'(HIST_MEM_DEPTH - 1);

    if (FIFO_DEPTH < 2 * (HIST_READ_LATENCY + 1) || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of two covering twice the histogram round trip");
    end

    readout_state_t state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d, rx_q, rx_d, hist_address_q, hist_address_d;
    logic [CW-1:0] inflight_q, inflight_d, fifo_count;
    logic [31:0] dropped_q, dropped_d;
    logic hist_valid_q, hist_valid_d, hist_read_q, hist_read_d, hist_rst_q, hist_rst_d, done_q, done_d;
    logic issue, push, pop;
    logic [HIST_WORD_SIZE:0] fifo_dout;

    // a bin is issued only if the FIFO can absorb it together with every return still in flight
    assign issue = state_q == SWEEP && 32'(fifo_count) + 32'(inflight_q) < 32'(FIFO_DEPTH);
    assign push  = hist_data_valid && state_q != IDLE;
    assign pop   = m_axis.tvalid && m_axis.tready;

    // next state, sweep/return/credit counters and the registered histogram port
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == IDLE && readout_start && fifo_count == '0) state_d = SWEEP;
        if (issue) begin
            sweep_d = sweep_q == LAST_BIN ? '0 : sweep_q + 1'b1;
            state_d = sweep_q == LAST_BIN ? DRAIN : SWEEP;
        end
        if (state_q == DRAIN && hist_last) state_d = IDLE;
        hist_address_d = state_q == IDLE ? bin_addr_in : sweep_q;
        hist_valid_d   = state_q == IDLE ? bin_valid_in : issue;
        hist_read_d    = state_q != IDLE;
        hist_rst_d     = state_q != IDLE;
        done_d         = state_q == DRAIN && hist_last;
        inflight_d     = inflight_q + CW'(issue) - CW'(push);
        rx_d           = !push ? rx_q : rx_q == LAST_BIN ? '0 : rx_q + 1'b1;
        dropped_d      = dropped_q + 32'(state_q != IDLE && bin_valid_in && dropped_q != '1);
    end

    // controller registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            sweep_q        <= '0;
            rx_q           <= '0;
            inflight_q     <= '0;
            dropped_q      <= '0;
            hist_address_q <= '0;
            hist_valid_q   <= 1'b0;
            hist_read_q    <= 1'b0;
            hist_rst_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sweep_q        <= sweep_d;
            rx_q           <= rx_d;
            inflight_q     <= inflight_d;
            dropped_q      <= dropped_d;
            hist_address_q <= hist_address_d;
            hist_valid_q   <= hist_valid_d;
            hist_read_q    <= hist_read_d;
            hist_rst_q     <= hist_rst_d;
            done_q         <= done_d;
        end
    end

    hist_readout_fifo #(.W(HIST_WORD_SIZE + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   ({rx_q == LAST_BIN, hist_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign busy          = state_q != IDLE;
    assign done          = done_q;
    assign dropped_count = dropped_q;
    assign hist_address  = hist_address_q;
    assign hist_valid    = hist_valid_q;
    assign hist_read     = hist_read_q;
    assign hist_rst      = hist_rst_q;
    assign m_axis.tvalid = fifo_count != '0;
    assign m_axis.tdata  = fifo_dout[HIST_WORD_SIZE-1:0];
    assign m_axis.tlast  = m_axis.tvalid && fifo_dout[HIST_WORD_SIZE];

endmodule

// File: tb/tb_hist_readout_ctrl.sv
// tb_hist_readout_ctrl: randomized readout scenarios against a histogram stand-in and a bin-count reference
module tb_hist_readout_ctrl;

    localparam int DEPTH = 64;
    localparam int WS    = 32;
    localparam int AW    = 6;
    localparam int FD    = 8;

    logic clk = 0, rstn = 1, readout_start = 0, bin_valid_in = 0;
    logic [AW-1:0] bin_addr_in = '0;
    logic busy, done, hist_valid, hist_read, hist_rst;
    logic [31:0] dropped_count;
    logic [AW-1:0] hist_address;
    logic [WS-1:0] hist_data;
    logic hist_data_valid;
    logic hist_last = 0;

    hist_readout_ctrl_if #(.WS(WS)) axis ();

    hist_readout_ctrl #(
        .HIST_MEM_DEPTH(DEPTH), .HIST_WORD_SIZE(WS), .HIST_MEM_ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rstn(rstn), .readout_start(readout_start), .busy(busy), .done(done),
        .bin_addr_in(bin_addr_in), .bin_valid_in(bin_valid_in), .dropped_count(dropped_count),
        .hist_address(hist_address), .hist_valid(hist_valid), .hist_read(hist_read), .hist_rst(hist_rst),
        .hist_data(hist_data), .hist_data_valid(hist_data_valid), .hist_last(hist_last), .m_axis(axis)
    );

    always #5 clk = ~clk;

    // histogram stand-in: increments in write mode, read-and-clear in read mode, 3-cycle return, last 2 cycles later
    int unsigned hmem [DEPTH];
    logic [2:0] pv = '0, pl = '0;
    logic [WS-1:0] pd [3] = '{default: '0};
    logic l1 = 0;
    always @(posedge clk) begin
        pv <= {pv[1:0], hist_valid && hist_read};
        pl <= {pl[1:0], hist_valid && hist_read && hist_address == AW'(DEPTH - 1)};
        pd[0] <= hmem[hist_address];
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        l1 <= pv[2] && pl[2];
        hist_last <= l1;
        if (hist_valid) hmem[hist_address] <= hist_read ? (hist_rst ? 0 : hmem[hist_address]) : hmem[hist_address] + 1;
    end
    assign hist_data       = pd[2];
    assign hist_data_valid = pv[2];

    int n_chk = 0, n_pass = 0;
    int unsigned refm [DEPTH];
    int unsigned expm [DEPTH];
    logic [WS:0] rxq [$];
    logic [WS:0] prev_word;
    int done_cnt = 0, done_base = 0, idx = 0, first_iss = 0, last_iss = 0, occ = 0, maxocc = 0, cyc = 0, mode = 0;
    logic prev_busy = 0, prev_stall = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        axis.tready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    end

    // bus monitor: collects words, checks hold under backpressure, sweep order, done timing and buffer occupancy
    always @(negedge clk) begin
        if (!rstn) begin
            occ = 0; prev_stall = 0; prev_busy = 0; idx = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_tvalid", 64'(axis.tvalid), 64'(1));
                chk("hold_word", 64'({axis.tlast, axis.tdata}), 64'(prev_word));
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_word = {axis.tlast, axis.tdata};
            if (axis.tvalid && axis.tready) rxq.push_back({axis.tlast, axis.tdata});
            if (done) begin
                done_cnt++;
                chk("done_at_busy_fall", 64'({prev_busy, busy}), 64'(2'b10));
            end
            prev_busy = busy;
            if (hist_valid && hist_read) begin
                chk("sweep_addr", 64'(hist_address), 64'(idx));
                if (idx == 0) first_iss = cyc;
                if (idx == DEPTH - 1) last_iss = cyc;
                idx++;
            end
            if (!busy) idx = 0;
            occ += int'(hist_data_valid && busy) - int'(axis.tvalid && axis.tready);
            if (occ > maxocc) maxocc = occ;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_bin(input int a);
        bin_addr_in = AW'(a);
        bin_valid_in = 1;
        if (!busy) refm[a]++;
        @(posedge clk); #1;
        bin_valid_in = 0;
    endtask

    task automatic random_fill(input int n);
        repeat (n) begin
            send_bin($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 1) idle(1);
        end
    endtask

    task automatic pulse_start();
        readout_start = 1;
        @(posedge clk); #1;
        readout_start = 0;
    endtask

    task automatic start_readout(input string tag);
        for (int i = 0; i < DEPTH; i++) begin expm[i] = refm[i]; refm[i] = 0; end
        done_base = done_cnt;
        maxocc = 0;
        pulse_start();
        chk({tag, "_busy"}, 64'(busy), 64'(1));
    endtask

    task automatic wait_readout(input string tag);
        int t = 0;
        while (!(done_cnt != done_base && rxq.size() >= DEPTH && !axis.tvalid) && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        chk({tag, "_in_time"}, 64'(t < 3000), 64'(1));
        idle(10);
        chk({tag, "_done_once"}, 64'(done_cnt - done_base), 64'(1));
        chk({tag, "_words"}, 64'(rxq.size()), 64'(DEPTH));
        chk({tag, "_no_overflow"}, 64'(maxocc <= FD), 64'(1));
        for (int i = 0; i < DEPTH && i < rxq.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), 64'(rxq[i][WS-1:0]), 64'(expm[i]));
            chk($sformatf("%s_last%0d", tag, i), 64'(rxq[i][WS]), 64'(i == DEPTH - 1));
        end
        rxq.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_dropped"}, 64'(dropped_count), 64'(0));
        chk({tag, "_hvalid"}, 64'(hist_valid), 64'(0));
        chk({tag, "_hread"}, 64'(hist_read), 64'(0));
        chk({tag, "_hrst"}, 64'(hist_rst), 64'(0));
        chk({tag, "_haddr"}, 64'(hist_address), 64'(0));
        chk({tag, "_tvalid"}, 64'(axis.tvalid), 64'(0));
        chk({tag, "_tlast"}, 64'(axis.tlast), 64'(0));
    endtask

    initial begin
        int t, n_swept;
        for (int i = 0; i < DEPTH; i++) begin hmem[i] = 0; refm[i] = 0; end
        #1 rstn = 0;
        idle(3);
        chk_reset("reset");
        rstn = 1;
        idle(2);
        // basic fill and readout at full rate, then an all-zero second readout
        send_bin(5); send_bin(5); send_bin(7);
        random_fill(20);
        idle(4);
        start_readout("t1"); wait_readout("t1");
        start_readout("t1b"); wait_readout("t1b");
        // slow sink forces the sweep to pause on credit
        mode = 1;
        send_bin(5); send_bin(5); send_bin(7);
        random_fill(20);
        idle(4);
        start_readout("t2"); wait_readout("t2");
        chk("t2_pause_seen", 64'(last_iss - first_iss > DEPTH - 1), 64'(1));
        // upstream traffic during the sweep is counted and dropped
        random_fill(10);
        idle(4);
        start_readout("t3");
        repeat (100) send_bin($urandom_range(0, DEPTH - 1));
        wait_readout("t3");
        chk("t3_dropped", 64'(dropped_count), 64'(100));
        mode = 0;
        start_readout("t3b"); wait_readout("t3b");
        // passthrough resumes on the very first idle cycle
        mode = 2;
        random_fill(10);
        idle(4);
        start_readout("t4");
        t = 0;
        while (busy && t < 3000) begin @(posedge clk); #1; t++; end
        chk("t4_busy_fell", 64'(busy), 64'(0));
        send_bin(DEPTH - 1); send_bin(DEPTH - 1);
        wait_readout("t4");
        mode = 0;
        start_readout("t4b"); wait_readout("t4b");
        // reset in the middle of a sweep
        for (int i = 0; i < DEPTH; i++) send_bin(i);
        random_fill(30);
        idle(4);
        start_readout("t5");
        t = 0;
        while (rxq.size() < 20 && t < 1000) begin @(posedge clk); #1; t++; end
        n_swept = idx;
        rstn = 0;
        @(negedge clk);
        chk_reset("t5_rst");
        chk("t5_swept_20", 64'(n_swept >= 20 && n_swept < DEPTH), 64'(1));
        for (int i = 0; i < DEPTH; i++) refm[i] = i < n_swept ? 0 : expm[i];
        rxq.delete();
        @(posedge clk); #1;
        rstn = 1;
        idle(6);
        start_readout("t5b"); wait_readout("t5b");
        // starts while busy or while the buffer still holds words are ignored
        mode = 1;
        random_fill(10);
        idle(4);
        start_readout("t6");
        repeat (4) begin
            idle($urandom_range(5, 20));
            pulse_start();
            chk("t6_still_busy", 64'(busy), 64'(1));
        end
        t = 0;
        while (busy && t < 3000) begin @(posedge clk); #1; t++; end
        chk("t6_fifo_nonempty", 64'(axis.tvalid), 64'(1));
        pulse_start();
        chk("t6_start_ignored", 64'(busy), 64'(0));
        wait_readout("t6");
        chk("t6_stays_idle", 64'(busy), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
